// File: rtl/alu_control_sequencer.sv
// alu_control_sequencer
//
// Hard-wired control unit for the single-bus datapath. It steps through
// fetch (T0-T2), operand staging (T3), ALU execute (T4) and write-back (T5)
// for register-register ALU instructions. At each step it drives the bus
// gates, register load enables, the memory read line and the one-hot ALU
// operation select that the datapath consumes.
//
// Ports
//   Clock       in   system clock, rising edge
//   Clear       in   synchronous active-high reset, wins over every state
//   IR[31:0]    in   instruction register. opcode [31:27], Ra (dest) [26:23],
//                    Rb [22:19], Rc [18:15]. Only looked at in T3..T5.
//   Mem_ready   in   memory read data valid, sampled in T1 only
//   Stop        in   halt request, sampled in T5 only
//   PCout, Zlowout, MDRout              out  bus-gate strobes
//   MARin, PCin, MDRin, IRin, Yin, Zin  out  register load enables
//   IncPC       out  ALU computes bus+1
//   Read        out  memory read / MDR source select
//   Rout[NREGS-1:0]  out  one-hot general-register bus gate (T3, T4)
//   Rin[NREGS-1:0]   out  one-hot general-register load enable (T5)
//   ADD, SUB, AND, OR, SHL, SHR, ROL, ROR  out  one-hot ALU select (T4)
//   Run         out  high in T0..T5, low in RESET and HALT
//
// All outputs are a combinational Moore decode of the state register. In
// T3..T5 the decode also uses the IR register fields. Any output that a
// state does not name is 0.

module alu_control_sequencer #(
    parameter int NREGS = 16
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic [31:0]      IR,
    input  logic             Mem_ready,
    input  logic             Stop,
    output logic             PCout,
    output logic             Zlowout,
    output logic             MDRout,
    output logic             MARin,
    output logic             PCin,
    output logic             MDRin,
    output logic             IRin,
    output logic             Yin,
    output logic             Zin,
    output logic             IncPC,
    output logic             Read,
    output logic [NREGS-1:0] Rout,
    output logic [NREGS-1:0] Rin,
    output logic             ADD,
    output logic             SUB,
    output logic             AND,
    output logic             OR,
    output logic             SHL,
    output logic             SHR,
    output logic             ROL,
    output logic             ROR,
    output logic             Run
);

    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_T0    = 3'd1,
        S_T1    = 3'd2,
        S_T2    = 3'd3,
        S_T3    = 3'd4,
        S_T4    = 3'd5,
        S_T5    = 3'd6,
        S_HALT  = 3'd7
    } state_t;

    state_t state;

    logic [4:0] opcode;
    logic [3:0] ir_ra;
    logic [3:0] ir_rb;
    logic [3:0] ir_rc;
    logic       legal_op;
    logic       unused_ir_bits;

    assign opcode = IR[31:27];
    assign ir_ra  = IR[26:23];
    assign ir_rb  = IR[22:19];
    assign ir_rc  = IR[18:15];

    // The eight ALU opcodes occupy 00000..00111. Anything else halts the block.
    assign legal_op = (opcode[4:3] == 2'b00);

    // The low IR bits belong to other instruction formats. This block ignores them.
    assign unused_ir_bits = ^IR[14:0];

    // Memory handshake: Read/MDRin are held in T1 until the memory raises
    // Mem_ready. The cycle where Mem_ready=1 is seen in T1 is the one that
    // captures the data. T2 (IRin) follows on the next clock. The memory may
    // drop Mem_ready at any time outside T1.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state <= S_RESET;
        end else begin
            case (state)
                S_RESET: state <= S_T0;
                S_T0:    state <= S_T1;
                S_T1:    state <= Mem_ready ? S_T2 : S_T1;
                S_T2:    state <= S_T3;
                S_T3:    state <= legal_op ? S_T4 : S_HALT;
                S_T4:    state <= S_T5;
                S_T5:    state <= Stop ? S_HALT : S_T0;
                S_HALT:  state <= S_HALT;
                default: state <= S_RESET;
            endcase
        end
    end

    always_comb begin
        PCout   = 1'b0;
        Zlowout = 1'b0;
        MDRout  = 1'b0;
        MARin   = 1'b0;
        PCin    = 1'b0;
        MDRin   = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        Zin     = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        Rout    = '0;
        Rin     = '0;
        ADD     = 1'b0;
        SUB     = 1'b0;
        AND     = 1'b0;
        OR      = 1'b0;
        SHL     = 1'b0;
        SHR     = 1'b0;
        ROL     = 1'b0;
        ROR     = 1'b0;
        Run     = 1'b0;

        case (state)
            S_T0: begin
                Run   = 1'b1;
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                // Reloading PC from an unchanged Z while waiting is harmless.
                Run     = 1'b1;
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                Run    = 1'b1;
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                Run = 1'b1;
                if (legal_op) begin
                    Rout[ir_rb] = 1'b1;
                    Yin         = 1'b1;
                end
            end
            S_T4: begin
                Run         = 1'b1;
                Rout[ir_rc] = 1'b1;
                Zin         = 1'b1;
                case (opcode)
                    5'b00000: ADD = 1'b1;
                    5'b00001: SUB = 1'b1;
                    5'b00010: AND = 1'b1;
                    5'b00011: ROL = 1'b1;
                    5'b00100: ROR = 1'b1;
                    5'b00101: OR  = 1'b1;
                    5'b00110: SHL = 1'b1;
                    5'b00111: SHR = 1'b1;
                    default:  ;
                endcase
            end
            S_T5: begin
                Run         = 1'b1;
                Zlowout     = 1'b1;
                Rin[ir_ra]  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
